// File: rtl/sd_sector_responder.sv
// rtl/sd_sector_responder.sv - sector-transfer responder between an SD-style initiator buffer and a word store
//
// Purpose: on an sd_rd/sd_wr request level, waits ACK_DELAY cycles, raises sd_ack
// and moves one 512-byte sector (256 x 16-bit words) between the initiator buffer
// and a word-addressed store. Out-of-range sectors run the full handshake without
// touching the store and pulse err at the end.
//
// Ports:
//   clk_sys       in   clock
//   reset         in   synchronous active-high reset
//   sd_lba        in   sector number, latched when a request is detected
//   sd_rd/sd_wr   in   read / write request levels (read wins if both high)
//   sd_ack        out  high for the whole transfer
//   sd_buff_addr  out  word index presented to the initiator buffer
//   sd_buff_dout  out  read data towards the initiator buffer
//   sd_buff_din   in   write data from the initiator buffer (2-cycle latency)
//   sd_buff_wr    out  one-cycle buffer write strobe
//   st_addr       out  store word address {lba[15:0], index}
//   st_rd/st_wr   out  one-cycle store request strobes
//   st_dout       out  store write data
//   st_din        in   store read data, valid with st_ready
//   st_ready      in   one-cycle completion of the outstanding store request
//   err           out  one-cycle pulse ending an out-of-range transfer

module sd_sector_responder #(
    parameter int ACK_DELAY = 4,
    parameter int SECTORS   = 64
) (
    input  logic        clk_sys,
    input  logic        reset,
    input  logic [31:0] sd_lba,
    input  logic        sd_rd,
    input  logic        sd_wr,
    output logic        sd_ack,
    output logic [7:0]  sd_buff_addr,
    output logic [15:0] sd_buff_dout,
    input  logic [15:0] sd_buff_din,
    output logic        sd_buff_wr,
    output logic [23:0] st_addr,
    output logic        st_rd,
    output logic        st_wr,
    output logic [15:0] st_dout,
    input  logic [15:0] st_din,
    input  logic        st_ready,
    output logic        err
);

    localparam logic [7:0]  ACK_LAST    = 8'(ACK_DELAY - 1);
    localparam logic [31:0] SECTORS_W   = 32'(SECTORS);
    localparam logic [7:0]  WR_LAT_LAST = 8'd1;
    localparam logic [7:0]  IDX_LAST    = 8'hFF;

    typedef enum logic [3:0] {
        S_IDLE,
        S_DELAY,
        S_RD_REQ,
        S_RD_WAIT,
        S_RD_PUSH,
        S_WR_ADDR,
        S_WR_LAT,
        S_WR_REQ,
        S_WR_WAIT,
        S_DONE
    } state_t;

    state_t      state_q, state_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [7:0]  idx_q, idx_d;
    logic [15:0] lba_q, lba_d;
    logic        rd_dir_q, rd_dir_d;
    logic        oor_q, oor_d;
    logic [7:0]  sd_buff_addr_q, sd_buff_addr_d;
    logic [15:0] sd_buff_dout_q, sd_buff_dout_d;
    logic [23:0] st_addr_q, st_addr_d;
    logic [15:0] st_dout_q, st_dout_d;

    // State register and datapath flops
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            state_q        <= S_IDLE;
            cnt_q          <= 8'd0;
            idx_q          <= 8'd0;
            lba_q          <= 16'd0;
            rd_dir_q       <= 1'b0;
            oor_q          <= 1'b0;
            sd_buff_addr_q <= 8'd0;
            sd_buff_dout_q <= 16'd0;
            st_addr_q      <= 24'd0;
            st_dout_q      <= 16'd0;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            idx_q          <= idx_d;
            lba_q          <= lba_d;
            rd_dir_q       <= rd_dir_d;
            oor_q          <= oor_d;
            sd_buff_addr_q <= sd_buff_addr_d;
            sd_buff_dout_q <= sd_buff_dout_d;
            st_addr_q      <= st_addr_d;
            st_dout_q      <= st_dout_d;
        end
    end

    // Next-state and datapath
    always_comb begin
        state_d        = state_q;
        cnt_d          = cnt_q;
        idx_d          = idx_q;
        lba_d          = lba_q;
        rd_dir_d       = rd_dir_q;
        oor_d          = oor_q;
        sd_buff_addr_d = sd_buff_addr_q;
        sd_buff_dout_d = sd_buff_dout_q;
        st_addr_d      = st_addr_q;
        st_dout_d      = st_dout_q;

        case (state_q)
            S_IDLE: begin
                cnt_d = 8'd0;
                idx_d = 8'd0;
                if (sd_rd || sd_wr) begin
                    // Range is judged on the full 32-bit LBA; only the low
                    // 16 bits are needed afterwards to form st_addr.
                    lba_d    = sd_lba[15:0];
                    rd_dir_d = sd_rd;
                    oor_d    = (sd_lba >= SECTORS_W);
                    state_d  = S_DELAY;
                end
            end
            S_DELAY: begin
                cnt_d = cnt_q + 8'd1;
                idx_d = 8'd0;
                if (cnt_q == ACK_LAST) begin
                    state_d = rd_dir_q ? S_RD_REQ : S_WR_ADDR;
                end
            end
            S_RD_REQ: begin
                if (oor_q) begin
                    // No store access: push a zero word straight away.
                    sd_buff_dout_d = 16'd0;
                    state_d        = S_RD_PUSH;
                end else begin
                    state_d = S_RD_WAIT;
                end
            end
            S_RD_WAIT: begin
                if (st_ready) begin
                    sd_buff_dout_d = st_din;
                    state_d        = S_RD_PUSH;
                end
            end
            S_RD_PUSH: begin
                idx_d   = idx_q + 8'd1;
                state_d = (idx_q == IDX_LAST) ? S_DONE : S_RD_REQ;
            end
            S_WR_ADDR: begin
                cnt_d   = 8'd0;
                state_d = S_WR_LAT;
            end
            S_WR_LAT: begin
                // Two cycles here plus the WR_ADDR cycle cover the buffer's
                // two-cycle read latency before sd_buff_din is sampled.
                cnt_d = cnt_q + 8'd1;
                if (cnt_q == WR_LAT_LAST) begin
                    st_dout_d = sd_buff_din;
                    state_d   = S_WR_REQ;
                end
            end
            S_WR_REQ: begin
                if (oor_q) begin
                    idx_d   = idx_q + 8'd1;
                    state_d = (idx_q == IDX_LAST) ? S_DONE : S_WR_ADDR;
                end else begin
                    state_d = S_WR_WAIT;
                end
            end
            S_WR_WAIT: begin
                if (st_ready) begin
                    idx_d   = idx_q + 8'd1;
                    state_d = (idx_q == IDX_LAST) ? S_DONE : S_WR_ADDR;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Addresses are loaded on entry so they are stable for the whole state.
        if ((state_d == S_RD_PUSH) || (state_d == S_WR_ADDR)) begin
            sd_buff_addr_d = idx_d;
        end
        if ((state_d == S_RD_REQ) || (state_d == S_WR_REQ)) begin
            st_addr_d = {lba_d, idx_d};
        end
    end

    // Outputs decoded from state
    always_comb begin
        sd_ack     = 1'b0;
        sd_buff_wr = 1'b0;
        st_rd      = 1'b0;
        st_wr      = 1'b0;
        err        = 1'b0;
        case (state_q)
            S_RD_REQ:  begin sd_ack = 1'b1; st_rd = ~oor_q; end
            S_RD_WAIT: sd_ack = 1'b1;
            S_RD_PUSH: begin sd_ack = 1'b1; sd_buff_wr = 1'b1; end
            S_WR_ADDR: sd_ack = 1'b1;
            S_WR_LAT:  sd_ack = 1'b1;
            S_WR_REQ:  begin sd_ack = 1'b1; st_wr = ~oor_q; end
            S_WR_WAIT: sd_ack = 1'b1;
            S_DONE:    err = oor_q;
            default:   sd_ack = 1'b0;
        endcase
    end

    assign sd_buff_addr = sd_buff_addr_q;
    assign sd_buff_dout = sd_buff_dout_q;
    assign st_addr      = st_addr_q;
    assign st_dout      = st_dout_q;

endmodule

// File: tb/tb_sd_sector_responder.sv
// tb/tb_sd_sector_responder.sv - self-checking bench for sd_sector_responder

module tb_sd_sector_responder;

    localparam int ACK_DELAY = 4;
    localparam int SECTORS   = 64;

    logic        clk_sys = 1'b0;
    logic        reset;
    logic [31:0] sd_lba;
    logic        sd_rd;
    logic        sd_wr;
    logic        sd_ack;
    logic [7:0]  sd_buff_addr;
    logic [15:0] sd_buff_dout;
    logic [15:0] sd_buff_din = 16'd0;
    logic        sd_buff_wr;
    logic [23:0] st_addr;
    logic        st_rd;
    logic        st_wr;
    logic [15:0] st_dout;
    logic [15:0] st_din = 16'd0;
    logic        st_ready;
    logic        err;

    sd_sector_responder #(
        .ACK_DELAY(ACK_DELAY),
        .SECTORS  (SECTORS)
    ) dut (
        .clk_sys     (clk_sys),
        .reset       (reset),
        .sd_lba      (sd_lba),
        .sd_rd       (sd_rd),
        .sd_wr       (sd_wr),
        .sd_ack      (sd_ack),
        .sd_buff_addr(sd_buff_addr),
        .sd_buff_dout(sd_buff_dout),
        .sd_buff_din (sd_buff_din),
        .sd_buff_wr  (sd_buff_wr),
        .st_addr     (st_addr),
        .st_rd       (st_rd),
        .st_wr       (st_wr),
        .st_dout     (st_dout),
        .st_din      (st_din),
        .st_ready    (st_ready),
        .err         (err)
    );

    always #5 clk_sys = ~clk_sys;

    int checks   = 0;
    int failures = 0;

    typedef struct packed {
        logic [23:0] addr;
        logic [15:0] data;
    } exp_t;

    exp_t rd_q[$];
    exp_t wr_q[$];

    typedef struct {
        logic [31:0] lba;
        logic        rd;
        logic        wr;
        int          lat_max;
        int          exp_buff_wr;
        int          exp_st_rd;
        int          exp_st_wr;
        int          exp_err;
    } vec_t;

    vec_t vecs[8];

    int          cnt_buff_wr, cnt_st_rd, cnt_st_wr, cnt_err, cnt_both, cnt_noack;
    logic [15:0] cur_lba;
    logic [7:0]  st_rd_idx;

    // Store model: answers each strobe after 1..lat_max cycles with the word
    // whose value equals the low 16 bits of its address.
    int          lat_max  = 1;
    int          rdy_wait = 0;
    logic [15:0] rdy_data = 16'd0;
    logic        rdy_resp = 1'b0;
    logic        rdy_spur = 1'b0;
    assign st_ready = rdy_resp | rdy_spur;

    always @(negedge clk_sys) begin
        rdy_resp = 1'b0;
        if (rdy_wait > 0) begin
            rdy_wait--;
            if (rdy_wait == 0) begin
                rdy_resp = 1'b1;
                st_din   = rdy_data;
            end
        end else if (st_rd || st_wr) begin
            rdy_wait = (lat_max <= 1) ? 1 : int'($urandom_range(lat_max, 1));
            rdy_data = st_addr[15:0];
        end
    end

    // Initiator buffer model: word n holds ~n, readable two cycles after the address.
    logic [7:0] ba_p1 = 8'd0;
    logic [7:0] ba_p2 = 8'd0;
    always @(negedge clk_sys) begin
        sd_buff_din = ~{8'h00, ba_p2};
        ba_p2       = ba_p1;
        ba_p1       = sd_buff_addr;
    end

    // Monitor / scoreboard
    always @(negedge clk_sys) begin
        exp_t e;
        if (sd_buff_wr) begin
            cnt_buff_wr++;
            if (!sd_ack) cnt_noack++;
            checks++;
            if (rd_q.size() == 0) begin
                failures++;
                $display("FAIL rd_unexpected actual addr=%0h data=%0h required=none", sd_buff_addr, sd_buff_dout);
            end else begin
                e = rd_q.pop_front();
                if (sd_buff_addr !== e.addr[7:0] || sd_buff_dout !== e.data) begin
                    failures++;
                    $display("FAIL rd_word actual addr=%0h data=%0h required addr=%0h data=%0h",
                             sd_buff_addr, sd_buff_dout, e.addr[7:0], e.data);
                end
            end
        end
        if (st_wr) begin
            cnt_st_wr++;
            if (!sd_ack) cnt_noack++;
            checks++;
            if (wr_q.size() == 0) begin
                failures++;
                $display("FAIL wr_unexpected actual addr=%0h data=%0h required=none", st_addr, st_dout);
            end else begin
                e = wr_q.pop_front();
                if (st_addr !== e.addr || st_dout !== e.data) begin
                    failures++;
                    $display("FAIL wr_word actual addr=%0h data=%0h required addr=%0h data=%0h",
                             st_addr, st_dout, e.addr, e.data);
                end
            end
        end
        if (st_rd) begin
            cnt_st_rd++;
            if (!sd_ack) cnt_noack++;
            checks++;
            if (st_addr !== {cur_lba, st_rd_idx}) begin
                failures++;
                $display("FAIL st_rd_addr actual=%0h required=%0h", st_addr, {cur_lba, st_rd_idx});
            end
            st_rd_idx++;
        end
        if (st_rd && st_wr) cnt_both++;
        if (err) cnt_err++;
    end

    task automatic chk(input string name, input logic [39:0] act, input logic [39:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_sd_ack"},       40'(sd_ack),       40'd0);
        chk({tag, "_sd_buff_addr"}, 40'(sd_buff_addr), 40'd0);
        chk({tag, "_sd_buff_dout"}, 40'(sd_buff_dout), 40'd0);
        chk({tag, "_sd_buff_wr"},   40'(sd_buff_wr),   40'd0);
        chk({tag, "_st_addr"},      40'(st_addr),      40'd0);
        chk({tag, "_st_rd"},        40'(st_rd),        40'd0);
        chk({tag, "_st_wr"},        40'(st_wr),        40'd0);
        chk({tag, "_st_dout"},      40'(st_dout),      40'd0);
        chk({tag, "_err"},          40'(err),          40'd0);
    endtask

    // Clear counters and push the expected words of `count` back-to-back transfers.
    task automatic prep(input logic [31:0] lba, input logic is_read, input int lat, input int count);
        logic oor;
        logic [7:0] n8;
        oor = (lba >= 32'(SECTORS));
        rd_q.delete();
        wr_q.delete();
        cnt_buff_wr = 0; cnt_st_rd = 0; cnt_st_wr = 0;
        cnt_err = 0; cnt_both = 0; cnt_noack = 0;
        cur_lba   = lba[15:0];
        st_rd_idx = 8'd0;
        lat_max   = lat;
        for (int t = 0; t < count; t++) begin
            for (int n = 0; n < 256; n++) begin
                n8 = 8'(n);
                if (is_read)
                    rd_q.push_back({16'h0, n8, (oor ? 16'h0 : {lba[7:0], n8})});
                else if (!oor)
                    wr_q.push_back({lba[15:0], n8, ~{8'h00, n8}});
            end
        end
    endtask

    task automatic wait_ack(input logic level, input int bound, output int n);
        n = 0;
        while (sd_ack !== level && n < bound) begin
            @(posedge clk_sys);
            #1;
            n++;
        end
    endtask

    task automatic run_transfer(input vec_t v);
        int n;
        prep(v.lba, v.rd, v.lat_max, 1);
        sd_lba = v.lba;
        sd_rd  = v.rd;
        sd_wr  = v.wr;
        @(posedge clk_sys);                 // request detect edge
        #1;
        wait_ack(1'b1, 20, n);
        chk("ack_delay", 40'(n), 40'(ACK_DELAY));
        sd_rd = 1'b0;
        sd_wr = 1'b0;
        wait_ack(1'b0, 5000, n);
        chk("ack_fall", 40'(sd_ack), 40'd0);
        repeat (3) @(negedge clk_sys);
        #1;
        chk("idle_after", 40'(sd_ack), 40'd0);
        chk("cnt_buff_wr", 40'(cnt_buff_wr), 40'(v.exp_buff_wr));
        chk("cnt_st_rd", 40'(cnt_st_rd), 40'(v.exp_st_rd));
        chk("cnt_st_wr", 40'(cnt_st_wr), 40'(v.exp_st_wr));
        chk("cnt_err", 40'(cnt_err), 40'(v.exp_err));
        chk("strobe_overlap", 40'(cnt_both), 40'd0);
        chk("strobe_no_ack", 40'(cnt_noack), 40'd0);
        chk("rd_q_left", 40'(rd_q.size()), 40'd0);
        chk("wr_q_left", 40'(wr_q.size()), 40'd0);
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        vec_t v;

        //          lba            rd    wr    lat  buff_wr st_rd st_wr err
        vecs[0] = '{32'd3,         1'b1, 1'b0, 1,   256,    256,  0,    0};
        vecs[1] = '{32'd5,         1'b0, 1'b1, 1,   0,      0,    256,  0};
        vecs[2] = '{32'd3,         1'b1, 1'b0, 7,   256,    256,  0,    0};
        vecs[3] = '{32'd64,        1'b1, 1'b0, 1,   256,    0,    0,    1};
        vecs[4] = '{32'd7,         1'b1, 1'b1, 3,   256,    256,  0,    0};
        vecs[5] = '{32'd63,        1'b0, 1'b1, 7,   0,      0,    256,  0};
        vecs[6] = '{32'd64,        1'b0, 1'b1, 1,   0,      0,    0,    1};
        vecs[7] = '{32'h0001_0002, 1'b1, 1'b0, 2,   256,    0,    0,    1};

        reset  = 1'b1;
        sd_lba = 32'd0;
        sd_rd  = 1'b0;
        sd_wr  = 1'b0;
        prep(32'd0, 1'b1, 1, 0);
        repeat (3) @(posedge clk_sys);
        #1;
        check_zero("reset");
        reset = 1'b0;
        @(negedge clk_sys);
        #1;

        // Stray st_ready while idle must not start anything.
        rdy_spur = 1'b1;
        @(negedge clk_sys);
        #1;
        rdy_spur = 1'b0;
        repeat (5) @(negedge clk_sys);
        #1;
        check_zero("idle_spur");

        for (int i = 0; i < 8; i++) begin
            run_transfer(vecs[i]);
        end

        // Request level held through DONE restarts a second transfer.
        prep(32'd100, 1'b1, 1, 2);
        sd_lba = 32'd100;
        sd_rd  = 1'b1;
        wait_ack(1'b1, 20, n);
        wait_ack(1'b0, 5000, n);
        wait_ack(1'b1, 20, n);
        chk("rearm_delay", 40'(n), 40'(ACK_DELAY + 2));
        sd_rd = 1'b0;
        wait_ack(1'b0, 5000, n);
        repeat (3) @(negedge clk_sys);
        #1;
        chk("rearm_buff_wr", 40'(cnt_buff_wr), 40'd512);
        chk("rearm_err", 40'(cnt_err), 40'd2);
        chk("rearm_st_rd", 40'(cnt_st_rd), 40'd0);

        // Both requests high reads; reset after word 100 aborts at once.
        prep(32'd9, 1'b1, 3, 1);
        sd_lba = 32'd9;
        sd_rd  = 1'b1;
        sd_wr  = 1'b1;
        wait_ack(1'b1, 20, n);
        sd_rd = 1'b0;
        sd_wr = 1'b0;
        n = 0;
        while (cnt_buff_wr < 100 && n < 3000) begin
            @(negedge clk_sys);
            #1;
            n++;
        end
        chk("mid_reached_100", 40'(cnt_buff_wr), 40'd100);
        chk("mid_st_wr", 40'(cnt_st_wr), 40'd0);
        reset = 1'b1;
        @(posedge clk_sys);
        #1;
        check_zero("mid_reset");
        @(negedge clk_sys);
        #1;
        chk("mid_no_more_wr", 40'(cnt_buff_wr), 40'd100);
        reset = 1'b0;
        @(negedge clk_sys);
        #1;
        v = '{32'd5, 1'b0, 1'b1, 1, 0, 0, 256, 0};
        run_transfer(v);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/sd_sector_responder.md
SD_SECTOR_RESPONDER -- requirements
Module: sd_sector_responder

Interface
REQ-001 SHALL have parameter ACK_DELAY, default 4, cycles from request detect to sd_ack rise (range 1..255).
REQ-002 SHALL have parameter SECTORS, default 64, number of valid sectors; LBAs at or above it are out of range.
REQ-003 SHALL have port clk_sys  in  1  the single clock; all logic rises on clk_sys.
REQ-004 SHALL have port reset  in  1  synchronous, active-high reset.
REQ-005 SHALL have port sd_lba  in  32  sector number, sampled at request detect.
REQ-006 SHALL have port sd_rd  in  1  read request level (store -> initiator buffer).
REQ-007 SHALL have port sd_wr  in  1  write request level (initiator buffer -> store).
REQ-008 SHALL have port sd_ack  out  1  high for the whole transfer.
REQ-009 SHALL have port sd_buff_addr  out  8  word index in the 512-byte sector (256 x 16-bit words).
REQ-010 SHALL have port sd_buff_dout  out  16  read data to initiator buffer.
REQ-011 SHALL have port sd_buff_din  in  16  write data from initiator buffer; valid 2 cycles after sd_buff_addr changes.
REQ-012 SHALL have port sd_buff_wr  out  1  one-cycle strobe; initiator writes sd_buff_dout at sd_buff_addr.
REQ-013 SHALL have port st_addr  out  24  store word address = {lba[15:0], word index}.
REQ-014 SHALL have ports st_rd / st_wr  out  1 each  one-cycle store request strobes.
REQ-015 SHALL have port st_dout  out  16  store write data.
REQ-016 SHALL have port st_din  in  16  store read data, valid when st_ready high.
REQ-017 SHALL have port st_ready  in  1  one-cycle completion of the outstanding st_rd/st_wr; may arrive the cycle after the strobe or later.
REQ-018 SHALL have port err  out  1  one-cycle pulse at end of an out-of-range transfer.

Function
REQ-019 SHALL implement states IDLE, DELAY, RD_REQ, RD_WAIT, RD_PUSH, WR_ADDR, WR_LAT, WR_REQ, WR_WAIT, DONE.
REQ-020 In IDLE, sd_rd or sd_wr high SHALL latch sd_lba, direction (read if sd_rd high, including both high) and go to DELAY with counter cleared.
REQ-021 DELAY SHALL last exactly ACK_DELAY cycles, then raise sd_ack and enter RD_REQ (read) or WR_ADDR (write) with word index 0.
REQ-022 Requests arriving outside IDLE SHALL be ignored; level still high on return to IDLE starts a new transfer.
REQ-023 Read: RD_REQ pulses st_rd one cycle with st_addr; RD_WAIT holds until st_ready, capturing st_din into sd_buff_dout; RD_PUSH pulses sd_buff_wr one cycle with sd_buff_addr = index, then increments index.
REQ-024 Write: WR_ADDR drives sd_buff_addr = index; WR_LAT waits 2 cycles; then st_dout captures sd_buff_din, WR_REQ pulses st_wr one cycle; WR_WAIT holds until st_ready, then increments index.
REQ-025 After index 255 completes, SHALL enter DONE, drop sd_ack for one cycle minimum, return to IDLE; exactly 256 words per transfer.
REQ-026 Index SHALL be 8-bit; wrap 255->0 only terminates the transfer, never restarts it.
REQ-027 Out-of-range LBA: full handshake still executes (ack, 256 sd_buff_wr strobes for read with sd_buff_dout = 0), no st_rd/st_wr issued, err pulses on entering DONE.
REQ-028 st_ready arriving when no request is outstanding SHALL be ignored.
REQ-029 sd_buff_wr, st_rd, st_wr SHALL never be high outside their defined states; st_rd and st_wr never simultaneously.

Reset
REQ-030 Reset SHALL force IDLE, counters and index 0, sd_ack 0, sd_buff_wr 0, st_rd 0, st_wr 0, err 0, sd_buff_addr 0, sd_buff_dout 0, st_addr 0, st_dout 0, at the next edge.
REQ-031 Reset mid-transfer SHALL abort immediately with outputs per REQ-030; an outstanding st_ready after reset is ignored.

Verification
REQ-032 Read LBA 3, store word n = 0x0300+n, st_ready 1 cycle after strobe -> sd_ack rises 4 cycles after sd_rd, 256 sd_buff_wr strobes, addr 0..255, data 0x0300..0x03FF, sd_ack then falls.
REQ-033 Write LBA 5, buffer word n = ~n -> 256 st_wr strobes, st_addr 0x000500..0x0005FF, st_dout = 0xFFFF..0xFF00, no sd_buff_wr.
REQ-034 Read with random st_ready latency 1..7 cycles -> data and order identical to REQ-032, no extra strobes.
REQ-035 Read LBA 64 (SECTORS=64) -> 256 strobes with data 0, zero st_rd, err single pulse at DONE.
REQ-036 sd_rd and sd_wr both high -> read transfer; reset asserted at word 100 -> all outputs 0 next cycle, next sd_wr completes normally from word 0.
